// File: rtl/keccak_absorb_pad.sv
// Packs message lanes into Keccak rate blocks and applies the suffix plus pad10*1 padding.
// Each block is held stable until block_ready_i. Message beats are refused while a block is pending.
module keccak_absorb_pad #(
    parameter int LANE_W         = 64,
    parameter int MAX_RATE_LANES = 21,
    parameter int RATE_WIDTH     = 11,
    parameter int SUFFIX_WIDTH   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [RATE_WIDTH-1:0]            rate_i,
    input  logic [SUFFIX_WIDTH-1:0]          suffix_i,
    input  logic                             msg_valid_i,
    output logic                             msg_ready_o,
    input  logic [LANE_W-1:0]                msg_data_i,
    input  logic [3:0]                       msg_bytes_i,
    input  logic                             msg_last_i,
    output logic                             block_valid_o,
    input  logic                             block_ready_i,
    output logic [MAX_RATE_LANES*LANE_W-1:0] block_data_o,
    output logic                             block_last_o
);
    localparam int BYTES = LANE_W / 8;
    localparam int CNT_W = $clog2(MAX_RATE_LANES + 1);
    localparam int BLK_W = MAX_RATE_LANES * LANE_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_PAD   = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        rl_q, rl_d;
    logic [SUFFIX_WIDTH-1:0] sfx_q, sfx_d;
    logic [BLK_W-1:0]        buf_q, buf_d;
    logic                    last_q, last_d;
    logic                    owe_q, owe_d;

    logic [RATE_WIDTH-1:0]   rate_lanes_raw;
    logic [CNT_W-1:0]        rl_in, rl_eff;
    logic [SUFFIX_WIDTH-1:0] sfx_eff;
    logic [3:0]              n_bytes;
    logic [LANE_W-1:0]       lane;
    logic                    accept;

    assign rate_lanes_raw = RATE_WIDTH'(rate_i / LANE_W);
    assign rl_in   = (rate_lanes_raw > RATE_WIDTH'(MAX_RATE_LANES)) ? CNT_W'(MAX_RATE_LANES)
                                                                    : CNT_W'(rate_lanes_raw);
    // Rate and suffix come straight from the inputs only on the first beat of a message.
    assign rl_eff  = (state_q == S_IDLE) ? rl_in : rl_q;
    assign sfx_eff = (state_q == S_IDLE) ? suffix_i : sfx_q;
    assign n_bytes = (msg_bytes_i > 4'(BYTES)) ? 4'(BYTES) : msg_bytes_i;

    assign msg_ready_o   = !rst_i && (((state_q == S_IDLE) && (rl_in != '0)) || (state_q == S_FILL));
    assign accept        = msg_valid_i && msg_ready_o;
    assign block_valid_o = (state_q == S_FLUSH);
    assign block_last_o  = (state_q == S_FLUSH) && last_q;
    assign block_data_o  = buf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rl_d    = rl_q;
        sfx_d   = sfx_q;
        buf_d   = buf_q;
        last_d  = last_q;
        owe_d   = owe_q;
        lane    = msg_data_i;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    rl_d  = rl_eff;
                    sfx_d = sfx_eff;
                    for (int k = 0; k < BYTES; k++) begin
                        if (msg_last_i && (k >= int'(n_bytes))) lane[8*k +: 8] = 8'h00;
                    end
                    buf_d[int'(cnt_q)*LANE_W +: LANE_W] = lane;
                    if (!msg_last_i) begin
                        if ((cnt_q + CNT_W'(1)) == rl_eff) begin
                            state_d = S_FLUSH;
                            cnt_d   = '0;
                            last_d  = 1'b0;
                            owe_d   = 1'b0;
                        end else begin
                            state_d = S_FILL;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                        // A full last beat that closes the block leaves no room: padding needs its own block.
                        if ((n_bytes == 4'(BYTES)) && ((cnt_q + CNT_W'(1)) == rl_eff)) begin
                            last_d = 1'b0;
                            owe_d  = 1'b1;
                        end else begin
                            last_d = 1'b1;
                            owe_d  = 1'b0;
                            if (n_bytes < 4'(BYTES))
                                buf_d[int'(cnt_q)*LANE_W + 8*int'(n_bytes) +: SUFFIX_WIDTH] ^= sfx_eff;
                            else
                                buf_d[(int'(cnt_q)+1)*LANE_W +: SUFFIX_WIDTH] ^= sfx_eff;
                            buf_d[(int'(rl_eff)-1)*LANE_W + LANE_W-8 +: 8] ^= 8'h80;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (block_ready_i) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (owe_q) begin
                        state_d = S_PAD;
                        owe_d   = 1'b0;
                    end else if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_PAD: begin
                buf_d = '0;
                buf_d[0 +: SUFFIX_WIDTH] = sfx_q;
                buf_d[(int'(rl_q)-1)*LANE_W + LANE_W-8 +: 8] ^= 8'h80;
                last_d  = 1'b1;
                state_d = S_FLUSH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rl_q    <= '0;
            sfx_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            owe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rl_q    <= rl_d;
            sfx_q   <= sfx_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            owe_q   <= owe_d;
        end
    end
endmodule

// File: tb/tb_keccak_absorb_pad.sv
// Bench for keccak_absorb_pad: directed vector table, hand sequences for stall/reset/rate switch,
// and random messages compared against a byte-level sponge padding model.
module tb_keccak_absorb_pad;
    localparam int BLK_W = 21 * 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [10:0]       rate_i;
    logic [7:0]        suffix_i;
    logic              msg_valid_i;
    logic              msg_ready_o;
    logic [63:0]       msg_data_i;
    logic [3:0]        msg_bytes_i;
    logic              msg_last_i;
    logic              block_valid_o;
    logic              block_ready_i;
    logic [BLK_W-1:0]  block_data_o;
    logic              block_last_o;

    keccak_absorb_pad dut (
        .clk_i(clk_i), .rst_i(rst_i), .rate_i(rate_i), .suffix_i(suffix_i),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
        .msg_bytes_i(msg_bytes_i), .msg_last_i(msg_last_i), .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i), .block_data_o(block_data_o), .block_last_o(block_last_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [BLK_W-1:0] exp_q[$];
    logic             exp_last_q[$];
    logic [BLK_W-1:0] got_q[$];
    logic             got_last_q[$];
    bit               stab_q[$];

    typedef struct {
        logic [10:0] rate;
        logic [7:0]  sfx;
        int          nfull;
        logic [3:0]  nb;
        logic [63:0] ldat;
        int          nblk;
        int          la;
        logic [63:0] va;
        int          lb;
        logic [63:0] vb;
    } vec_t;
    vec_t vt[7];

    function automatic logic [63:0] full_lane(input int i);
        return {32'hF00D0000 | 32'(i), 32'hA5A50000 | 32'(i)};
    endfunction

    task automatic chk(input string nm, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Sponge padding: message || suffix || 0* with 0x80 folded into the final rate byte.
    task automatic model(input int rl, input logic [7:0] sfx, input logic [7:0] msg[$]);
        logic [7:0] p[$];
        logic [BLK_W-1:0] blk;
        int r, total, nblk;
        r = rl * 8;
        p = msg;
        total = (p.size() / r + 1) * r;
        p.push_back(sfx);
        while (p.size() < total) p.push_back(8'h00);
        p[total-1] = p[total-1] ^ 8'h80;
        nblk = total / r;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int i = 0; i < r; i++) blk[8*i +: 8] = p[b*r + i];
            exp_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int guard = 0;
        msg_valid_i = 1'b1;
        msg_data_i  = d;
        msg_bytes_i = nb;
        msg_last_i  = last;
        #1;
        while (!msg_ready_o && guard < 500) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL msg_ready_timeout got 0 want 1");
        end
        @(posedge clk_i);
        @(negedge clk_i);
        msg_valid_i = 1'b0;
    endtask

    task automatic send_msg(input logic [10:0] rate, input logic [7:0] sfx, input int nfull,
                            input logic [3:0] nb, input logic [63:0] ldat, input bit rnd,
                            input int sw_beat, input logic [10:0] sw_rate);
        logic [63:0] bq[$];
        logic [7:0]  mb[$];
        logic [63:0] d;
        int n;
        for (int i = 0; i < nfull; i++) begin
            d = rnd ? {$urandom, $urandom} : full_lane(i);
            bq.push_back(d);
            for (int k = 0; k < 8; k++) mb.push_back(d[8*k +: 8]);
        end
        n = (nb > 4'd8) ? 8 : int'(nb);
        for (int k = 0; k < n; k++) mb.push_back(ldat[8*k +: 8]);
        model(int'(rate) / 64, sfx, mb);
        rate_i   = rate;
        suffix_i = sfx;
        for (int i = 0; i < nfull; i++) begin
            if (i == sw_beat) begin
                rate_i   = sw_rate;
                suffix_i = ~sfx;
            end
            send_beat(bq[i], 4'd0, 1'b0);
        end
        send_beat(ldat, nb, 1'b1);
    endtask

    task automatic drain(output logic [BLK_W-1:0] fb, output logic [BLK_W-1:0] lb, output int nblk);
        int guard = 0;
        logic [BLK_W-1:0] g;
        logic gl;
        nblk = 0;
        fb = '0;
        lb = '0;
        while (got_q.size() < exp_q.size() && guard < 4000) begin
            @(negedge clk_i);
            #2;
            guard++;
        end
        repeat (4) @(negedge clk_i);
        #2;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL blk_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g  = got_q.pop_front();
            gl = got_last_q.pop_front();
            chk("blk_data", g, exp_q.pop_front());
            chk("blk_last", BLK_W'(gl), BLK_W'(exp_last_q.pop_front()));
            if (nblk == 0) fb = g;
            lb = g;
            nblk++;
        end
        while (stab_q.size() > 0) begin
            checks++;
            if (!stab_q.pop_front()) begin
                errors++;
                $display("FAIL blk_stable got changed want held");
            end
        end
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk_i);
    endtask

    // Block-side monitor: drives ready, captures handshakes, notes whether stalled blocks held.
    initial begin : monitor
        logic [BLK_W-1:0] pd;
        logic pl;
        bit ps;
        ps = 1'b0;
        pd = '0;
        pl = 1'b0;
        block_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            case (rdy_mode)
                0:       block_ready_i = 1'b1;
                1:       block_ready_i = 1'($urandom_range(0, 1));
                default: block_ready_i = 1'b0;
            endcase
            #1;
            if (rst_i) begin
                ps = 1'b0;
            end else begin
                if (ps) stab_q.push_back(block_valid_o && block_data_o == pd && block_last_o == pl);
                if (block_valid_o && block_ready_i) begin
                    got_q.push_back(block_data_o);
                    got_last_q.push_back(block_last_o);
                end
                ps = block_valid_o && !block_ready_i;
                pd = block_data_o;
                pl = block_last_o;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [BLK_W-1:0] fb, lb, d0;
        int nblk;
        vt[0] = '{11'd1088, 8'h06, 0,  4'd0,  64'hDEADBEEFCAFEF00D, 1, 0,  64'h06, 16, 64'h8000000000000000};
        vt[1] = '{11'd576,  8'h06, 8,  4'd7,  64'h00FFFFFFFFFFFFFF, 1, 8,  64'h86FFFFFFFFFFFFFF, 7, full_lane(7)};
        vt[2] = '{11'd1344, 8'h1F, 20, 4'd8,  64'h0123456789ABCDEF, 2, 0,  64'h1F, 20, 64'h8000000000000000};
        vt[3] = '{11'd1088, 8'h06, 2,  4'd3,  64'h1122334455667788, 1, 2,  64'h0000000006667788, 16, 64'h8000000000000000};
        vt[4] = '{11'd1088, 8'h1F, 16, 4'd0,  64'hFFFFFFFFFFFFFFFF, 1, 16, 64'h800000000000001F, 15, full_lane(15)};
        vt[5] = '{11'd576,  8'h06, 7,  4'd8,  64'hDEADBEEF01234567, 1, 8,  64'h8000000000000006, 7, 64'hDEADBEEF01234567};
        vt[6] = '{11'd576,  8'h1F, 0,  4'd12, 64'hCAFEF00D12345678, 1, 0,  64'hCAFEF00D12345678, 1, 64'h1F};

        rst_i = 1'b1;
        rate_i = 11'd1088;
        suffix_i = 8'h06;
        msg_valid_i = 1'b0;
        msg_data_i = '0;
        msg_bytes_i = '0;
        msg_last_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        chk("rst_msg_ready", BLK_W'(msg_ready_o), '0);
        chk("rst_blk_valid", BLK_W'(block_valid_o), '0);
        chk("rst_blk_last", BLK_W'(block_last_o), '0);
        chk("rst_blk_data", block_data_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", BLK_W'(msg_ready_o), BLK_W'(1));
        rate_i = 11'd0;
        #1;
        chk("rate0_ready", BLK_W'(msg_ready_o), '0);
        rate_i = 11'd1088;
        @(negedge clk_i);

        rdy_mode = 1;
        for (int t = 0; t < 7; t++) begin
            send_msg(vt[t].rate, vt[t].sfx, vt[t].nfull, vt[t].nb, vt[t].ldat, 1'b0, -1, 11'd0);
            drain(fb, lb, nblk);
            chk($sformatf("vec%0d_nblk", t), BLK_W'(nblk), BLK_W'(vt[t].nblk));
            chk($sformatf("vec%0d_lane%0d", t, vt[t].la), BLK_W'(lb[64*vt[t].la +: 64]), BLK_W'(vt[t].va));
            chk($sformatf("vec%0d_lane%0d", t, vt[t].lb), BLK_W'(lb[64*vt[t].lb +: 64]), BLK_W'(vt[t].vb));
        end

        // Stalled block must hold while the message side stays closed.
        rdy_mode = 2;
        send_msg(11'd1088, 8'h1F, 0, 4'd0, 64'h0, 1'b0, -1, 11'd0);
        #2;
        chk("stall_valid0", BLK_W'(block_valid_o), BLK_W'(1));
        d0 = block_data_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #2;
            chk("stall_valid", BLK_W'(block_valid_o), BLK_W'(1));
            chk("stall_data", block_data_o, d0);
            chk("stall_msg_ready", BLK_W'(msg_ready_o), '0);
        end
        chk("stall_no_xfer", BLK_W'(got_q.size()), '0);
        rdy_mode = 0;
        drain(fb, lb, nblk);
        chk("stall_one_xfer", BLK_W'(nblk), BLK_W'(1));
        chk("stall_valid_after", BLK_W'(block_valid_o), '0);

        // Reset in the middle of a message discards it.
        rate_i = 11'd1088;
        suffix_i = 8'h06;
        for (int i = 0; i < 5; i++) send_beat(full_lane(i), 4'd0, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", BLK_W'(block_valid_o), '0);
        chk("mid_rst_last", BLK_W'(block_last_o), '0);
        chk("mid_rst_data", block_data_o, '0);
        chk("mid_rst_ready", BLK_W'(msg_ready_o), '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mid_post_rst_ready", BLK_W'(msg_ready_o), BLK_W'(1));
        @(negedge clk_i);
        send_msg(11'd1088, 8'h06, 0, 4'd0, 64'h0, 1'b0, -1, 11'd0);
        drain(fb, lb, nblk);
        chk("after_rst_nblk", BLK_W'(nblk), BLK_W'(1));
        chk("after_rst_block", lb, {BLK_W'(64'h8000000000000000) << (64*16)} | BLK_W'(64'h06));

        // Rate/suffix switched mid-message, then a back-to-back message.
        send_msg(11'd1088, 8'h06, 16, 4'd0, 64'h0, 1'b0, 3, 11'd576);
        send_msg(11'd576, 8'h06, 0, 4'd0, 64'h0, 1'b0, -1, 11'd0);
        drain(fb, lb, nblk);
        chk("sw_nblk", BLK_W'(nblk), BLK_W'(2));
        chk("sw_lane16", BLK_W'(fb[64*16 +: 64]), BLK_W'(64'h8000000000000006));
        chk("sw_lane8", BLK_W'(fb[64*8 +: 64]), BLK_W'(full_lane(8)));
        chk("b2b_lane8", BLK_W'(lb[64*8 +: 64]), BLK_W'(64'h8000000000000000));

        rdy_mode = 1;
        for (int g = 0; g < 8; g++) begin
            for (int m = 0; m < 3; m++) begin
                case ($urandom_range(0, 3))
                    0:       rate_i = 11'd1088;
                    1:       rate_i = 11'd576;
                    default: rate_i = 11'd1344;
                endcase
                send_msg(rate_i, ($urandom_range(0, 1) != 0) ? 8'h1F : 8'h06, $urandom_range(0, 45),
                         4'($urandom_range(0, 11)), {$urandom, $urandom}, 1'b1, -1, 11'd0);
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
            end
            drain(fb, lb, nblk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keccak_absorb_pad.md
KECCAK_ABSORB_PAD -- requirements
Module: keccak_absorb_pad

Interface
REQ-001 SHALL have parameter LANE_W, default 64, meaning Keccak lane width in bits.
REQ-002 SHALL have parameter MAX_RATE_LANES, default 21, meaning the largest rate in lanes (1344/64).
REQ-003 SHALL have port clk_i  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rate_i  input  RATE_WIDTH  rate in bits from the SHA3 parameter setup stage (1088/576/1344/0).
REQ-006 SHALL have port suffix_i  input  SUFFIX_WIDTH  domain suffix byte plus first pad bit (0x06 or 0x1F).
REQ-007 SHALL have port msg_valid_i  input  1  message beat valid.
REQ-008 SHALL have port msg_ready_o  output  1  message beat accepted when high with msg_valid_i.
REQ-009 SHALL have port msg_data_i  input  LANE_W  message lane; byte k is bits [8k+7:8k] (little-endian).
REQ-010 SHALL have port msg_bytes_i  input  4  valid byte count of a last beat (0..8); ignored on non-last beats.
REQ-011 SHALL have port msg_last_i  input  1  final beat of the message.
REQ-012 SHALL have port block_valid_o  output  1  rate block available.
REQ-013 SHALL have port block_ready_i  input  1  downstream (absorb/permutation) accepts the block.
REQ-014 SHALL have port block_data_o  output  MAX_RATE_LANES*LANE_W  block; lane j at bits [64j+63:64j]; lanes at or above the rate are zero.
REQ-015 SHALL have port block_last_o  output  1  block is the final padded block of the message.

Function
REQ-016 SHALL implement states IDLE, FILL, FLUSH, PAD.
REQ-017 SHALL, in IDLE, latch rate_lanes = rate_i/64 and suffix_i on the first accepted beat; mid-message changes to rate_i/suffix_i SHALL be ignored.
REQ-018 SHALL hold msg_ready_o low in IDLE while rate_i == 0, and low in FLUSH and PAD.
REQ-019 SHALL, on an accepted non-last beat, write msg_data_i to lane cnt and increment cnt; if cnt+1 == rate_lanes, go to FLUSH with pending_last = 0 and cnt = 0.
REQ-020 SHALL, on an accepted last beat with n = min(msg_bytes_i, 8): write lane cnt with bytes >= n zeroed; if n < 8, XOR the suffix into byte n of lane cnt, else XOR it into byte 0 of lane cnt+1.
REQ-021 SHALL XOR 0x80 into byte 7 of lane rate_lanes-1 of the final block; when this byte coincides with the suffix byte, the result SHALL be suffix^0x80 (e.g. 0x86).
REQ-022 SHALL, when n == 8 and cnt+1 == rate_lanes, go to FLUSH with pending_last = 0 and then enter PAD; otherwise go to FLUSH with pending_last = 1.
REQ-023 SHALL, in PAD, build a block holding only suffix in lane 0 byte 0 and 0x80 in lane rate_lanes-1 byte 7, and present it one cycle later with block_last_o = 1.
REQ-024 SHALL assert block_valid_o in FLUSH, starting the cycle after the completing beat is accepted; block_data_o and block_last_o SHALL be stable while block_valid_o is high and block_ready_i is low.
REQ-025 SHALL, on handshake (block_valid_o & block_ready_i), zero the buffer and go to: PAD if a pad block is owed, IDLE if block_last_o was 1, else FILL.
REQ-026 SHALL accept a zero-length message as one last beat with msg_bytes_i = 0.
REQ-027 SHALL have no combinational path from block_ready_i to msg_ready_o.

Reset
REQ-028 SHALL, while rst_i is high, force state IDLE, cnt 0, buffer zero, latched rate/suffix 0, block_valid_o 0, block_last_o 0, block_data_o 0, and msg_ready_o 0; an in-progress message SHALL be discarded.
REQ-029 SHALL raise msg_ready_o in the first cycle after rst_i deasserts, provided rate_i != 0.

Verification
REQ-030 SHALL cover: SHA3-256 (rate 1088), single last beat with bytes=0 -> one block, lane0 = 0x06, lane16 = 0x8000000000000000, all other lanes 0, block_last_o = 1.
REQ-031 SHALL cover: SHA3-512 (rate 576), 9 beats, last beat bytes=7 data 0x00FFFFFFFFFFFFFF -> one block, lane8 = 0x86FFFFFFFFFFFFFF, block_last_o = 1.
REQ-032 SHALL cover: SHAKE128 (rate 1344), 21 full beats, last beat bytes=8 -> block 1 holds the data with block_last_o = 0; block 2 has lane0 = 0x1F, lane20 = 0x8000000000000000, block_last_o = 1.
REQ-033 SHALL cover: SHAKE256 with block_ready_i low for 5 cycles after block_valid_o -> block_data_o unchanged, msg_ready_o = 0 throughout; one transfer when ready rises.
REQ-034 SHALL cover: rst_i pulsed after 5 beats of a SHA3-256 message -> outputs zero; a following empty message yields exactly the REQ-030 block.
REQ-035 SHALL cover: rate_i switched from 1088 to 576 mid-message -> block still 17 lanes wide, padded at lane16; back-to-back messages with no idle gap.
